// File: rtl/axi_pkg.sv
// Shared encodings for the AXI burst master: FSM states, burst types and
// response codes, plus a response-severity helper.
package axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// Beat counter shared by the W and R paths; last_o flags the beat whose
// index equals the AXI LEN value.
module axi_beat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [7:0] len_i,
  output logic       last_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= 8'd0;
    else if (inc_i)   cnt_q <= cnt_q + 8'd1;
  end

  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 burst master: converts one command into an AW/W/B
// or AR/R sequence and pulses done with the burst response.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [DATA_WIDTH/8-1:0] wd_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [1:0]              AWBURST,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [ID_WIDTH-1:0]     WID,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [7:0]              ARLEN,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            resp_q;
  logic                  err_q;

  logic       w_hs, r_hs, beat_last, beat_clr;
  logic       rd_err;
  logic [1:0] rd_resp_d;
  logic       unused_bid;

  // B responses are not ID-checked; with one burst outstanding BID is implied.
  assign unused_bid = ^BID;

  assign w_hs     = (state_q == S_WDATA) && wd_valid && WREADY;
  assign r_hs     = (state_q == S_RDATA) && RVALID && rd_ready;
  assign beat_clr = (w_hs && beat_last) || (r_hs && RLAST);

  axi_beat_cnt u_beat (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (beat_clr),
    .inc_i  (w_hs || r_hs),
    .len_i  (len_q),
    .last_o (beat_last)
  );

  // A short burst or a foreign RID anywhere in the burst overrides the worst RRESP.
  assign rd_err    = err_q || (RID != id_q) || !beat_last;
  assign rd_resp_d = rd_err ? RESP_SLVERR : resp_max(resp_q, RRESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          id_q    <= cmd_id;
          len_q   <= cmd_len;
          size_q  <= cmd_size;
          resp_q  <= RESP_OKAY;
          err_q   <= 1'b0;
          state_q <= cmd_write ? S_WADDR : S_RADDR;
        end
        S_WADDR: if (AWREADY) state_q <= S_WDATA;
        S_WDATA: if (w_hs && beat_last) state_q <= S_WRESP;
        S_WRESP: if (BVALID) state_q <= S_IDLE;
        S_RADDR: if (ARREADY) state_q <= S_RDATA;
        S_RDATA: if (r_hs) begin
          resp_q <= resp_max(resp_q, RRESP);
          err_q  <= err_q || (RID != id_q);
          if (RLAST) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;

  assign AWADDR  = addr_q;
  assign AWID    = id_q;
  assign AWBURST = BURST_INCR;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWVALID = (state_q == S_WADDR);

  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign WID      = id_q;
  assign WVALID   = (state_q == S_WDATA) && wd_valid;
  assign wd_ready = (state_q == S_WDATA) && WREADY;
  assign WLAST    = (state_q == S_WDATA) && beat_last;

  assign BREADY = (state_q == S_WRESP);

  assign ARADDR  = addr_q;
  assign ARID    = id_q;
  assign ARBURST = BURST_INCR;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign ARVALID = (state_q == S_RADDR);

  assign rd_valid = (state_q == S_RDATA) && RVALID;
  assign RREADY   = (state_q == S_RDATA) && rd_ready;
  assign rd_data  = RDATA;
  assign rd_last  = (state_q == S_RDATA) && RLAST;

  // Completion is signalled on the finishing handshake itself, so the
  // following cycle is the IDLE cycle that accepts the next command.
  assign done      = !rst && (((state_q == S_WRESP) && BVALID) || (r_hs && RLAST));
  assign done_resp = !done ? RESP_OKAY : (state_q == S_WRESP) ? BRESP : rd_resp_d;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed plus randomized bench for axi_burst_master; the slave side is
// driven cycle by cycle and outcomes come from a burst-level model.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_id;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  done_resp;
  logic [31:0] AWADDR;
  logic [15:0] AWID;
  logic [1:0]  AWBURST;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [15:0] WID;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [15:0] BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [15:0] ARID;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY;
  logic [15:0] RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;

  int n_chk  = 0;
  int n_pass = 0;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWID(AWID), .AWBURST(AWBURST), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WID(WID), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLEN(ARLEN),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_slave();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
    ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; RID = 0; RDATA = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
  endtask

  // wmode: 0 = WREADY always high, 1 = toggling, 2 = random. rst_beat >= 0
  // fires a reset once that many W beats have been accepted.
  task automatic do_write(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                          input logic [2:0] size, input int awdly, input int wmode,
                          input logic [1:0] bresp, input int rst_beat);
    int cyc, beat, aw_cnt, done_cnt;
    bit aw_done, early_w, b_pend;
    logic [31:0] cur;
    logic [3:0]  strb;
    cyc = 0; beat = 0; aw_cnt = 0; done_cnt = 0; aw_done = 0; early_w = 0; b_pend = 0;
    @(negedge clk); idle_slave();
    cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_id = id; cmd_len = len; cmd_size = size;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    cur = $urandom; strb = 4'($urandom);
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      cmd_valid = 0;
      if (beat == rst_beat) begin
        rst = 1;
        #1 chk("rst_no_done", done, 0);
        @(negedge clk); rst = 0;
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        return;
      end
      AWREADY  = (cyc > awdly);
      WREADY   = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      wd_valid = 1; wd_data = cur; wd_strb = strb;
      BVALID = b_pend; BRESP = bresp; BID = id;
      #1;
      if (AWVALID && AWREADY) begin
        aw_cnt++;
        chk("awaddr", AWADDR, addr);
        chk("awid", AWID, id);
        chk("awlen", AWLEN, len);
        chk("awsize", AWSIZE, size);
        chk("awburst", AWBURST, 2'b01);
      end
      if (WVALID && !aw_done) early_w = 1;
      if (WVALID && WREADY) begin
        chk("wdata", WDATA, cur);
        chk("wstrb", WSTRB, strb);
        chk("wid", WID, id);
        chk("wlast", WLAST, beat == int'(len));
        beat++;
        cur = $urandom; strb = 4'($urandom);
        if (beat == int'(len) + 1) b_pend = 1;
      end
      if (done) begin
        done_cnt++;
        chk("wr_done_resp", done_resp, bresp);
        chk("busy_at_done", cmd_ready, 0);
      end
      if (AWVALID && AWREADY) aw_done = 1;
    end
    chk("aw_count", aw_cnt, 1);
    chk("w_beats", beat, int'(len) + 1);
    chk("w_before_aw", early_w, 0);
    chk("wr_done_count", done_cnt, 1);
  endtask

  // rlast_beat: beat index carrying RLAST; bad_beat: beat with a foreign RID (-1 none);
  // resps: two bits of RRESP per beat.
  task automatic do_read(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                         input logic [2:0] size, input int ardly, input int rmode,
                         input int rlast_beat, input int bad_beat, input logic [31:0] resps);
    int cyc, beat, ar_cnt, done_cnt;
    bit ar_done;
    logic [1:0]  exp_resp, r;
    logic [31:0] cur;
    // Burst-level expectation: worst response seen, unless the burst is short or mis-tagged.
    exp_resp = 2'b00;
    for (int i = 0; i <= rlast_beat; i++) begin
      r = resps[2*i +: 2];
      if (r > exp_resp) exp_resp = r;
    end
    if (rlast_beat != int'(len) || (bad_beat >= 0 && bad_beat <= rlast_beat)) exp_resp = 2'b10;
    cyc = 0; beat = 0; ar_cnt = 0; done_cnt = 0; ar_done = 0;
    @(negedge clk); idle_slave();
    cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_id = id; cmd_len = len; cmd_size = size;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    cur = $urandom;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      cmd_valid = 0;
      ARREADY  = (cyc > ardly);
      RVALID   = ar_done && (beat <= rlast_beat);
      RDATA    = cur;
      RRESP    = resps[2*(beat % 16) +: 2];
      RLAST    = (beat == rlast_beat);
      RID      = (beat == bad_beat) ? (id ^ 16'h0001) : id;
      rd_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (ARVALID && ARREADY) begin
        ar_cnt++;
        chk("araddr", ARADDR, addr);
        chk("arid", ARID, id);
        chk("arlen", ARLEN, len);
        chk("arsize", ARSIZE, size);
        chk("arburst", ARBURST, 2'b01);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, cur);
        chk("rd_last", rd_last, beat == rlast_beat);
        beat++;
        cur = $urandom;
      end
      if (done) begin
        done_cnt++;
        chk("rd_done_resp", done_resp, exp_resp);
        chk("busy_at_done", cmd_ready, 0);
      end
      if (ARVALID && ARREADY) ar_done = 1;
    end
    chk("ar_count", ar_cnt, 1);
    chk("r_beats", beat, rlast_beat + 1);
    chk("rd_done_count", done_cnt, 1);
  endtask

  initial begin
    int l, rb, bb;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_id = 0; cmd_len = 0; cmd_size = 0;
    idle_slave();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_awvalid", AWVALID, 0);
    chk("reset_arvalid", ARVALID, 0);
    chk("reset_bready", BREADY, 0);
    chk("reset_done", done, 0);
    rst = 0;
    #1 chk("post_reset_cmd_ready", cmd_ready, 1);

    do_write(32'h1000, 16'd5, 8'd3, 3'd2, 0, 0, 2'b00, -1);
    do_read(32'h2000, 16'd9, 8'd0, 3'd2, 0, 0, 0, -1, 32'h0);
    do_write(32'h3000, 16'd7, 8'd7, 3'd2, 3, 1, 2'b00, -1);
    do_read(32'h4000, 16'd3, 8'd3, 3'd2, 1, 0, 1, -1, 32'h0);
    do_read(32'h5000, 16'd4, 8'd3, 3'd2, 0, 0, 3, -1, 32'h0000_000C);
    do_read(32'h5100, 16'd4, 8'd3, 3'd2, 0, 1, 3, 2, 32'h0);
    do_write(32'h6000, 16'd2, 8'd0, 3'd1, 2, 0, 2'b10, -1);
    do_write(32'h7000, 16'd6, 8'd3, 3'd2, 0, 0, 2'b00, 2);
    do_read(32'h8000, 16'd8, 8'd2, 3'd2, 0, 0, 2, -1, 32'h0000_0001);

    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, 16'($urandom), 8'(l), 3'($urandom_range(0, 2)),
                 $urandom_range(0, 3), 2, 2'($urandom), -1);
      end else begin
        rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : l;
        bb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
        do_read($urandom, 16'($urandom), 8'(l), 3'($urandom_range(0, 2)),
                $urandom_range(0, 3), 1, rb, bb, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
